// File: rtl/systolic_tile_if.sv
// Tile command, operand-skew and result handshake bundle between the systolic
// tile sequencer (slave) and its command source / operand buffers / consumer (master).
interface systolic_tile_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int KW   = 9
);
    logic                 start_valid;
    logic                 start_ready;
    logic [KW-1:0]        cfg_k;
    logic                 start_tile;
    logic [ROWS-1:0]      row_a_valid;
    logic [ROWS*KW-1:0]   row_k_idx;
    logic [COLS-1:0]      col_b_valid;
    logic [COLS*KW-1:0]   col_k_idx;
    logic                 res_valid;
    logic                 res_ready;
    logic                 busy;
    logic [15:0]          tile_count;

    modport master (
        output start_valid, cfg_k, res_ready,
        input  start_ready, start_tile, row_a_valid, row_k_idx,
               col_b_valid, col_k_idx, res_valid, busy, tile_count
    );

    modport slave (
        input  start_valid, cfg_k, res_ready,
        output start_ready, start_tile, row_a_valid, row_k_idx,
               col_b_valid, col_k_idx, res_valid, busy, tile_count
    );
endinterface

// File: rtl/systolic_tile_ctrl.sv
// Sequencer for a ROWS x COLS systolic GEMM grid: clears accumulators, streams
// skewed operand enables/K-indices, then holds a result handshake once the wavefront drains.
module systolic_tile_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int K_MAX = 256,
    parameter int KW    = $clog2(K_MAX + 1)
) (
    input logic            clk,
    input logic            rst,
    systolic_tile_if.slave bus
);
    localparam int SKEW      = 2 * (ROWS + COLS - 2) + 1;
    localparam int T_END_MAX = K_MAX + SKEW;
    localparam int TW        = $clog2(T_END_MAX + 1);

    // IDLE: accept command | CLEAR: start_tile pulse | RUN: stream operands | CAPTURE: hold result
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, CAPTURE} state_t;

    state_t              state;
    state_t              state_next;
    logic [TW-1:0]       t;
    logic [TW-1:0]       t_next;
    logic [TW-1:0]       t_end;
    logic [KW-1:0]       k_lat;
    logic [KW-1:0]       k_clamped;
    logic                start_hs;
    logic                res_hs;
    logic [ROWS-1:0]     row_valid_next;
    logic [ROWS*KW-1:0]  row_idx_next;
    logic [COLS-1:0]     col_valid_next;
    logic [COLS*KW-1:0]  col_idx_next;

    logic                start_tile_r;
    logic [ROWS-1:0]     row_valid_r;
    logic [ROWS*KW-1:0]  row_idx_r;
    logic [COLS-1:0]     col_valid_r;
    logic [COLS*KW-1:0]  col_idx_r;
    logic                res_valid_r;
    logic [15:0]         tile_cnt;

    assign k_clamped = (bus.cfg_k > KW'(K_MAX)) ? KW'(K_MAX) : bus.cfg_k;
    assign t_end     = TW'(k_lat) + TW'(SKEW);
    assign start_hs  = bus.start_valid && (state == IDLE);
    assign res_hs    = (state == CAPTURE) && bus.res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        t_next     = '0;
        unique case (state)
            IDLE: begin
                if (start_hs) state_next = CLEAR;
            end
            CLEAR: begin
                state_next = RUN;
            end
            RUN: begin
                if (t == t_end) state_next = CAPTURE;
                else            t_next     = t + TW'(1);
            end
            CAPTURE: begin
                if (bus.res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Enables are computed from the upcoming t so the registered outputs line up with it.
    always_comb begin
        row_valid_next = '0;
        row_idx_next   = '0;
        col_valid_next = '0;
        col_idx_next   = '0;
        for (int i = 0; i < ROWS; i++) begin
            if ((state_next == RUN) && (t_next >= TW'(2 * i)) &&
                (t_next < TW'(2 * i) + TW'(k_lat))) begin
                row_valid_next[i]          = 1'b1;
                row_idx_next[i*KW +: KW]   = KW'(t_next - TW'(2 * i));
            end
        end
        for (int j = 0; j < COLS; j++) begin
            if ((state_next == RUN) && (t_next >= TW'(2 * j)) &&
                (t_next < TW'(2 * j) + TW'(k_lat))) begin
                col_valid_next[j]          = 1'b1;
                col_idx_next[j*KW +: KW]   = KW'(t_next - TW'(2 * j));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t            <= '0;
            k_lat        <= '0;
            start_tile_r <= 1'b0;
            row_valid_r  <= '0;
            row_idx_r    <= '0;
            col_valid_r  <= '0;
            col_idx_r    <= '0;
            res_valid_r  <= 1'b0;
            tile_cnt     <= '0;
        end else begin
            t            <= t_next;
            if (start_hs) k_lat <= k_clamped;
            start_tile_r <= (state_next == CLEAR);
            row_valid_r  <= row_valid_next;
            row_idx_r    <= row_idx_next;
            col_valid_r  <= col_valid_next;
            col_idx_r    <= col_idx_next;
            res_valid_r  <= (state_next == CAPTURE);
            if (res_hs) tile_cnt <= tile_cnt + 16'd1;
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.start_tile  = start_tile_r;
    assign bus.row_a_valid = row_valid_r;
    assign bus.row_k_idx   = row_idx_r;
    assign bus.col_b_valid = col_valid_r;
    assign bus.col_k_idx   = col_idx_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.tile_count  = tile_cnt;
endmodule

// File: doc/systolic_tile_ctrl.md
Name: systolic_tile_ctrl

Overview:
Sequencer for a ROWS x COLS grid of systolic GEMM processing elements. It accepts a tile command with reduction length K and pulses the grid's start_tile clear. It then drives skewed per-row a_valid / per-column b_valid enables and K-indices to the operand buffers, waits for the wavefront to drain, and presents a result handshake while every PE's psum_out is final and stable. PEs do not know K and never assert their own psum_valid; this block is the sole authority on when partial sums are complete.

Parameters:
ROWS, 4, PE grid rows (A operand rows).
COLS, 4, PE grid columns (B operand columns).
K_MAX, 256, largest supported reduction length.
KW, $clog2(K_MAX+1), width of cfg_k and of each K-index field.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start_valid  in  1  tile command valid.
start_ready  out  1  high only in IDLE.
cfg_k  in  KW  reduction length, sampled on start handshake.
start_tile  out  1  accumulator clear to all PEs.
row_a_valid  out  ROWS  a_valid for the left-edge PE of row i.
row_k_idx  out  ROWS*KW  K-index of the A element row i must present this cycle; field i = bits [i*KW +: KW].
col_b_valid  out  COLS  b_valid for the top-edge PE of column j.
col_k_idx  out  COLS*KW  K-index for column j, same packing.
res_valid  out  1  all PE psum_out final and stable.
res_ready  in  1  consumer has captured psums.
busy  out  1  state != IDLE.
tile_count  out  16  completed tiles, wraps at 2^16.

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; start_tile=0, all valids 0, all k_idx 0, res_valid=0, busy=0, tile_count=0. Reset mid-tile abandons the tile. The valids drop on the same edge; PE contents are not this block's concern.
- Latched K: k_lat = min(cfg_k, K_MAX), captured when start_valid & start_ready.
- States: IDLE -> CLEAR -> RUN -> CAPTURE -> IDLE.
- IDLE: start_ready=1. On handshake, go to CLEAR.
- CLEAR: exactly 1 cycle. start_tile=1, all valids 0. Then RUN with t=0.
- RUN: counter t increments each cycle from 0 to T_END = k_lat + 2*(ROWS+COLS-2) + 1. At t==T_END, go to CAPTURE.
- Row enables: row_a_valid[i] = (2i <= t < 2i+k_lat); row_k_idx[i] = t-2i when valid, else 0.
- Column enables: col_b_valid[j] = (2j <= t < 2j+k_lat); col_k_idx[j] = t-2j when valid, else 0.
- Skew rationale: 2 cycles per PE hop (input register plus output register), so A and B element k meet at PE(i,j) simultaneously. The final acc reaches psum_out of PE(ROWS-1,COLS-1) in the first CAPTURE cycle.
- Valids and k_idx are registered outputs, driven from the t value of the same cycle. start_tile never overlaps any valid.
- k_lat=0: no special path. Valids never assert; RUN lasts 2*(ROWS+COLS-2)+2 cycles; results are all zero.
- CAPTURE: res_valid=1, all valids 0, start_tile 0. It stays until res_ready=1. On the res_valid & res_ready cycle: go to IDLE and increment tile_count. res_ready outside CAPTURE is ignored.
- Back-to-back tiles: start_ready rises the cycle after the result handshake. Minimum tile period is k_lat + 2*(ROWS+COLS-2) + 5 cycles.
- start_valid while busy is not accepted; cfg_k changes while busy have no effect.
- tile_count wraps from 0xFFFF to 0.

Test Plan:
- Reset: hold rst 2 cycles, then release -> all outputs 0, start_ready=1, tile_count=0.
- Basic tile, ROWS=COLS=4, cfg_k=3, res_ready tied 1, handshake at c0:
  - start_tile=1 at c0+1.
  - row_a_valid[0] at c0+2..c0+4; row_a_valid[3] at c0+8..c0+10 with row_k_idx[3]=0,1,2.
  - res_valid at c0+19 for 1 cycle; tile_count=1.
  - With PEs attached and A, B = small integer matrices, captured psums equal the reference product.
- Backpressure: cfg_k=5, res_ready=0 for 10 cycles after res_valid rises -> res_valid held; start_ready=0 throughout; IDLE entered the cycle after res_ready=1.
- Edge K values:
  - cfg_k=0 -> no valid ever high; res_valid at c0+16; psums 0.
  - cfg_k=400 (K_MAX=256) -> clamped; row_a_valid[0] high exactly 256 cycles.
- Reset mid-RUN: rst at t=6 with cfg_k=8 -> next cycle all valids 0, IDLE, tile_count unchanged. A new command then completes normally.
- Back-to-back: two commands (cfg_k=2, then 4), start_valid held high -> second accepted the cycle after the first result handshake. tile_count=2, and no start_tile overlaps any valid.
